safe_lockout_ctrl: RTL and testbench

SAFE_LOCKOUT_CTRL -- requirements
Module: safe_lockout_ctrl

---
 rtl/safe_pkg.sv | 13 +
 rtl/safe_timer.sv | 20 ++
 rtl/safe_lockout_ctrl.sv | 97 +++++++++
 tb/tb_safe_lockout_ctrl.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/safe_pkg.sv
// Shared types and parameter defaults for the safe lockout controller.
package safe_pkg;
  typedef enum logic [1:0] {
    LOCKED    = 2'd0,
    UNLOCKED  = 2'd1,
    DOOR_AJAR = 2'd2,
    LOCKOUT   = 2'd3
  } lock_state_t;

  localparam logic [15:0] DEF_UNLOCK_CYCLES  = 16'd1000;
  localparam logic [15:0] DEF_LOCKOUT_CYCLES = 16'd5000;
  localparam logic [1:0]  DEF_MAX_FAILS      = 2'd3;
endpackage

// File: rtl/safe_timer.sv
// 16-bit saturating down-counter for the unlock and lockout windows.
module safe_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        en,
  output logic        zero
);
  logic [15:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst)                     r_cnt <= '0;
    else if (load)               r_cnt <= load_val;
    else if (en && r_cnt != '0)  r_cnt <= r_cnt - 16'd1;
  end

  // Flags the final cycle of a window: a loaded count of N yields exactly N cycles.
  assign zero = (r_cnt <= 16'd1);
endmodule

// File: rtl/safe_lockout_ctrl.sv
// Lock state machine: unlock window, door-ajar hold, and failed-attempt lockout.
module safe_lockout_ctrl
  import safe_pkg::*;
#(
  parameter logic [15:0] UNLOCK_CYCLES  = DEF_UNLOCK_CYCLES,
  parameter logic [15:0] LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES,
  parameter logic [1:0]  MAX_FAILS      = DEF_MAX_FAILS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       res_val,
  input  logic       res_ok,
  input  logic       door_closed,
  input  logic       relock_req,
  output logic       accept_en,
  output logic       unlock,
  output logic       locked_out,
  output logic       ajar,
  output logic [1:0] fail_cnt
);
  lock_state_t r_state, w_state_nxt;
  logic [1:0]  r_fail, w_fail_nxt;
  logic [2:0]  w_fail_inc;
  logic        w_load, w_en, w_zero;
  logic [15:0] w_load_val;

  safe_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (w_load),
    .load_val (w_load_val),
    .en       (w_en),
    .zero     (w_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= LOCKED;
      r_fail  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_fail  <= w_fail_nxt;
    end
  end

  // Widened so MAX_FAILS=3 compares without overflow.
  assign w_fail_inc = {1'b0, r_fail} + 3'd1;
  assign w_en       = (r_state == UNLOCKED) || (r_state == LOCKOUT);

  always_comb begin
    w_state_nxt = r_state;
    w_fail_nxt  = r_fail;
    w_load      = 1'b0;
    w_load_val  = '0;
    case (r_state)
      LOCKED: begin
        if (res_val) begin
          if (res_ok) begin
            w_state_nxt = UNLOCKED;
            w_load      = 1'b1;
            w_load_val  = UNLOCK_CYCLES;
            w_fail_nxt  = '0;
          end else if (w_fail_inc >= {1'b0, MAX_FAILS}) begin
            w_state_nxt = LOCKOUT;
            w_load      = 1'b1;
            w_load_val  = LOCKOUT_CYCLES;
            w_fail_nxt  = MAX_FAILS;
          end else begin
            w_fail_nxt  = w_fail_inc[1:0];
          end
        end
      end
      UNLOCKED: begin
        if (relock_req || w_zero) w_state_nxt = door_closed ? LOCKED : DOOR_AJAR;
      end
      DOOR_AJAR: begin
        if (door_closed) w_state_nxt = LOCKED;
      end
      LOCKOUT: begin
        if (w_zero) begin
          w_state_nxt = LOCKED;
          w_fail_nxt  = '0;
        end
      end
      default: begin
        w_state_nxt = LOCKED;
        w_fail_nxt  = '0;
      end
    endcase
  end

  assign accept_en  = (r_state == LOCKED);
  assign unlock     = (r_state == UNLOCKED);
  assign ajar       = (r_state == DOOR_AJAR);
  assign locked_out = (r_state == LOCKOUT);
  assign fail_cnt   = r_fail;
endmodule

// File: tb/tb_safe_lockout_ctrl.sv
// Directed bench for safe_lockout_ctrl with a cycle-level behavioural model.
module tb_safe_lockout_ctrl;
  localparam int UNL = 4;
  localparam int LO  = 6;
  localparam int MF  = 3;
  localparam int M_LOCKED = 0, M_OPEN = 1, M_AJAR = 2, M_LOCKOUT = 3;

  logic clk = 1'b0;
  logic rst = 1'b0, res_val = 1'b0, res_ok = 1'b0, door_closed = 1'b1, relock_req = 1'b0;
  logic accept_en, unlock, locked_out, ajar;
  logic [1:0] fail_cnt;

  int n_checks = 0, n_err = 0;
  bit chk_en = 1'b0;
  int m_mode = M_LOCKED, m_left = 0, m_fail = 0;

  safe_lockout_ctrl #(
    .UNLOCK_CYCLES  (16'd4),
    .LOCKOUT_CYCLES (16'd6),
    .MAX_FAILS      (2'd3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .res_val     (res_val),
    .res_ok      (res_ok),
    .door_closed (door_closed),
    .relock_req  (relock_req),
    .accept_en   (accept_en),
    .unlock      (unlock),
    .locked_out  (locked_out),
    .ajar        (ajar),
    .fail_cnt    (fail_cnt)
  );

  always #5 clk = ~clk;

  // Model: what mode the lock is in, how many cycles of the current window remain.
  always @(posedge clk) begin
    if (rst) begin
      m_mode = M_LOCKED; m_fail = 0; m_left = 0;
    end else begin
      case (m_mode)
        M_LOCKED: if (res_val) begin
          if (res_ok) begin m_mode = M_OPEN; m_left = UNL; m_fail = 0; end
          else if (m_fail + 1 >= MF) begin m_mode = M_LOCKOUT; m_left = LO; m_fail = MF; end
          else m_fail = m_fail + 1;
        end
        M_OPEN: begin
          m_left = m_left - 1;
          if (relock_req || m_left == 0) m_mode = door_closed ? M_LOCKED : M_AJAR;
        end
        M_AJAR: if (door_closed) m_mode = M_LOCKED;
        default: begin
          m_left = m_left - 1;
          if (m_left == 0) begin m_mode = M_LOCKED; m_fail = 0; end
        end
      endcase
    end
  end

  always @(negedge clk) begin
    logic [5:0] act, exp;
    if (chk_en) begin
      act = {accept_en, unlock, locked_out, ajar, fail_cnt};
      exp = {m_mode == M_LOCKED, m_mode == M_OPEN, m_mode == M_LOCKOUT,
             m_mode == M_AJAR, 2'(m_fail)};
      n_checks++;
      if (act !== exp) begin
        n_err++;
        $display("FAIL model t=%0t acc/unl/lo/ajar/fail got %b want %b", $time, act, exp);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic pulse(input logic ok);
    res_val = 1'b1; res_ok = ok;
    step();
    res_val = 1'b0; res_ok = 1'b0;
  endtask

  // Counts cycles a window output stays high; optionally injects a res_val mid-window.
  task automatic count_high(input int which, input int inject_at, output int n);
    n = 0;
    while ((which == 0 ? unlock : locked_out) && n < 40) begin
      if (n == inject_at) begin res_val = 1'b1; res_ok = 1'b1; end
      n++;
      step();
      res_val = 1'b0; res_ok = 1'b0;
    end
  endtask

  initial begin
    int n;
    step();
    rst = 1'b1; step(); rst = 1'b0;
    chk_en = 1'b1;
    chk("rst_accept", accept_en, 1);
    chk("rst_unlock", unlock, 0);
    chk("rst_fail", fail_cnt, 0);

    // Correct code, door closed: 4 cycles open.
    pulse(1'b1);
    count_high(0, -1, n);
    chk("unlock_len", n, 4);
    chk("unlock_exit_acc", accept_en, 1);
    chk("unlock_exit_fail", fail_cnt, 0);

    // Three wrong codes: lockout for 6 cycles, res_val ignored inside.
    pulse(1'b0); chk("fail1", fail_cnt, 1);
    pulse(1'b0); chk("fail2", fail_cnt, 2);
    pulse(1'b0); chk("lo_enter", locked_out, 1); chk("lo_acc", accept_en, 0);
    count_high(1, 2, n);
    chk("lockout_len", n, 6);
    chk("lo_exit_fail", fail_cnt, 0);
    chk("lo_exit_acc", accept_en, 1);

    // Two wrong, one right, then one wrong.
    pulse(1'b0); pulse(1'b0);
    pulse(1'b1); chk("recover_unl", unlock, 1); chk("recover_fail", fail_cnt, 0);
    count_high(0, -1, n);
    pulse(1'b0); chk("after_fail", fail_cnt, 1); chk("after_no_lo", locked_out, 0);

    // Door open at expiry.
    door_closed = 1'b0;
    pulse(1'b1); step(4);
    chk("ajar_on", ajar, 1); chk("ajar_unl", unlock, 0);
    step(2); chk("ajar_hold", ajar, 1);
    door_closed = 1'b1; step();
    chk("ajar_exit", accept_en, 1);

    // Early relock in the 2nd unlock cycle.
    pulse(1'b1); step();
    relock_req = 1'b1; step(); relock_req = 1'b0;
    chk("relock_unl", unlock, 0); chk("relock_acc", accept_en, 1);

    // Relock coincident with final cycle, door open -> ajar.
    door_closed = 1'b0;
    pulse(1'b1); step(3);
    relock_req = 1'b1; step(); relock_req = 1'b0;
    chk("relock_last_ajar", ajar, 1);
    door_closed = 1'b1; step();

    // Relock in LOCKED has no effect.
    relock_req = 1'b1; step(2); relock_req = 1'b0;
    chk("relock_locked", accept_en, 1);

    // Reset in the 3rd lockout cycle with res_val.
    pulse(1'b0); pulse(1'b0); pulse(1'b0);
    step(2);
    rst = 1'b1; res_val = 1'b1; res_ok = 1'b1;
    step();
    rst = 1'b0; res_val = 1'b0; res_ok = 1'b0;
    chk("rst_lo_acc", accept_en, 1); chk("rst_lo_fail", fail_cnt, 0);
    chk("rst_lo_unl", unlock, 0); chk("rst_lo_lo", locked_out, 0);
    step(3);
    chk("rst_lo_still", unlock, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
